// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller slice.
package irq_pkg;

  // Arbitration/presentation FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_PRESENT = 2'd2
  } irq_state_e;

  // Register map
  localparam logic [23:0] ADDR_PRI_LO = 24'h002020;
  localparam logic [23:0] ADDR_PRI_HI = 24'h002021;
  localparam logic [23:0] ADDR_ENABLE = 24'h002023;
  localparam logic [23:0] ADDR_FLAGS  = 24'h002027;

  // Parameter defaults
  localparam int unsigned NUM_IRQ_DEFAULT  = 8;
  localparam logic [7:0]  VEC_BASE_DEFAULT = 8'h03;

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational arbiter: highest 2-bit priority among eligible sources,
// ties resolved toward the lowest index.
module irq_priority_encoder
#(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned IDX_W   = 3
) (
  input  logic [NUM_IRQ-1:0]   i_elig,
  input  logic [2*NUM_IRQ-1:0] i_pri,
  output logic                 o_valid,
  output logic [IDX_W-1:0]     o_index
);

  logic             w_found;
  logic [1:0]       w_best;
  logic [IDX_W-1:0] w_idx;

  // Scan upward; strict greater-than keeps the earlier index on a tie
  always_comb begin
    w_found = 1'b0;
    w_best  = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (i_elig[i] && (!w_found || (i_pri[2*i +: 2] > w_best))) begin
        w_found = 1'b1;
        w_best  = i_pri[2*i +: 2];
        w_idx   = IDX_W'(i);
      end
    end
  end

  assign o_valid = w_found;
  assign o_index = w_idx;

endmodule

// File: rtl/irq_controller.sv
// Prioritised interrupt controller: edge-detected flags, per-source enable
// and 2-bit priority, CPU level masking, single-vector presentation.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ  = NUM_IRQ_DEFAULT,
  parameter logic [7:0]  VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bus_write,
  input  logic               bus_read,
  input  logic [23:0]        bus_address_in,
  input  logic [7:0]         bus_data_in,
  output logic [7:0]         bus_data_out,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [1:0]         cpu_ilevel,
  output logic               cpu_irq,
  output logic [7:0]         cpu_irq_vector,
  input  logic               cpu_irq_ack
);

  localparam int unsigned IDX_W = $clog2(NUM_IRQ);

  logic [2*NUM_IRQ-1:0] r_pri;
  logic [2*NUM_IRQ-1:0] w_pri_nxt;
  logic [NUM_IRQ-1:0]   r_en;
  logic [NUM_IRQ-1:0]   w_en_nxt;
  logic [NUM_IRQ-1:0]   r_flag;
  logic [NUM_IRQ-1:0]   w_flag_nxt;
  logic [NUM_IRQ-1:0]   r_irq_q;
  logic [NUM_IRQ-1:0]   w_rise;
  logic [NUM_IRQ-1:0]   w_clr;
  logic [NUM_IRQ-1:0]   w_elig;
  logic [NUM_IRQ-1:0]   w_elig_nxt;
  irq_state_e           r_state;
  irq_state_e           w_state_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_win_idx;
  logic                 w_win_valid;
  logic                 w_ack;
  logic                 w_wr_pri_lo;
  logic                 w_wr_pri_hi;
  logic                 w_wr_en;
  logic                 w_wr_flag;

  function automatic logic [NUM_IRQ-1:0] f_elig(
    input logic [NUM_IRQ-1:0]   flag,
    input logic [NUM_IRQ-1:0]   en,
    input logic [2*NUM_IRQ-1:0] pri,
    input logic [1:0]           lvl
  );
    logic [NUM_IRQ-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      res[i] = flag[i] && en[i] && (pri[2*i +: 2] != 2'd0) && (pri[2*i +: 2] > lvl);
    end
    return res;
  endfunction

  assign w_wr_pri_lo = bus_write && (bus_address_in == ADDR_PRI_LO);
  assign w_wr_pri_hi = bus_write && (bus_address_in == ADDR_PRI_HI);
  assign w_wr_en     = bus_write && (bus_address_in == ADDR_ENABLE);
  assign w_wr_flag   = bus_write && (bus_address_in == ADDR_FLAGS);
  assign w_rise      = irq_in & ~r_irq_q;
  assign w_ack       = cpu_irq_ack && (r_state == ST_PRESENT);

  // Next register contents from bus writes, edges and acknowledge
  always_comb begin
    w_pri_nxt = r_pri;
    if (w_wr_pri_lo) w_pri_nxt[7:0]  = bus_data_in;
    if (w_wr_pri_hi) w_pri_nxt[15:8] = bus_data_in;
    w_en_nxt = w_wr_en ? bus_data_in : r_en;
    w_clr = '0;
    if (w_wr_flag) w_clr = bus_data_in;
    if (w_ack)     w_clr[r_idx] = 1'b1;
    // a new edge overrides any clear of the same bit
    w_flag_nxt = (r_flag & ~w_clr) | w_rise;
  end

  // Arbitration uses the registered state; withdrawal looks at the values
  // about to be registered so the request drops on the edge that removes it.
  assign w_elig     = f_elig(r_flag, r_en, r_pri, cpu_ilevel);
  assign w_elig_nxt = f_elig(w_flag_nxt, w_en_nxt, w_pri_nxt, cpu_ilevel);

  irq_priority_encoder #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_prio (
    .i_elig  (w_elig),
    .i_pri   (r_pri),
    .o_valid (w_win_valid),
    .o_index (w_win_idx)
  );

  // Configuration, flag and edge-detect registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pri   <= '0;
      r_en    <= '0;
      r_flag  <= '0;
      r_irq_q <= '0;
    end else begin
      r_pri   <= w_pri_nxt;
      r_en    <= w_en_nxt;
      r_flag  <= w_flag_nxt;
      r_irq_q <= irq_in;
    end
  end

  // FSM state and captured winner index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_ARB) && w_win_valid) r_idx <= w_win_idx;
    end
  end

  // Next-state logic: idle -> arbitrate -> present -> idle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (|w_elig) w_state_nxt = ST_ARB;
      ST_ARB:     w_state_nxt = w_win_valid ? ST_PRESENT : ST_IDLE;
      ST_PRESENT: if (w_ack || !w_elig_nxt[r_idx]) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // CPU-facing request and vector, active only while presenting
  always_comb begin
    cpu_irq        = 1'b0;
    cpu_irq_vector = '0;
    if (r_state == ST_PRESENT) begin
      cpu_irq        = 1'b1;
      cpu_irq_vector = VEC_BASE + 8'(r_idx);
    end
  end

  // Register read-back mux
  always_comb begin
    bus_data_out = '0;
    if (bus_read) begin
      case (bus_address_in)
        ADDR_PRI_LO: bus_data_out = r_pri[7:0];
        ADDR_PRI_HI: bus_data_out = r_pri[15:8];
        ADDR_ENABLE: bus_data_out = r_en;
        ADDR_FLAGS:  bus_data_out = r_flag;
        default:     bus_data_out = '0;
      endcase
    end
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8: number of interrupt sources, fixed at 8 for the register map below.
REQ-002 SHALL have parameter VEC_BASE, default 8'h03: vector number of source 0.
REQ-003 SHALL have port clk  in  1  system clock; the only clock.
REQ-004 SHALL have port reset  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port bus_write  in  1  register write strobe, one clk cycle.
REQ-006 SHALL have port bus_read  in  1  register read strobe; has no side effects.
REQ-007 SHALL have port bus_address_in  in  24  register address.
REQ-008 SHALL have port bus_data_in  in  8  write data.
REQ-009 SHALL have port bus_data_out  out  8  read data; combinational.
REQ-010 SHALL have port irq_in  in  NUM_IRQ  source requests from the timer and other peripherals.
REQ-011 SHALL have port cpu_ilevel  in  2  current CPU interrupt mask level.
REQ-012 SHALL have port cpu_irq  out  1  interrupt request to the CPU.
REQ-013 SHALL have port cpu_irq_vector  out  8  vector of the presented source.
REQ-014 SHALL have port cpu_irq_ack  in  1  CPU acknowledge, one-cycle pulse.

Function
REQ-015 Register map SHALL be:
  - 0x2020: pri[3:0], 2 bits per source, sources 0-3.
  - 0x2021: pri[7:4], sources 4-7.
  - 0x2023: enable mask.
  - 0x2027: flags; a write of 1 clears the bit.
  - All other addresses read 8'h00.
REQ-016 Writes SHALL take effect on the posedge of clk where bus_write=1; they are visible on bus_data_out the next cycle.
REQ-017 Flag[i] SHALL set on a rising edge of irq_in[i], detected against a registered copy, regardless of enable.
REQ-018 When a flag set and a write-1-clear of the same bit occur in the same cycle, the set SHALL win.
REQ-019 Source i SHALL be eligible when all hold: flag=1, enable=1, pri!=0, pri>cpu_ilevel.
REQ-020 The winner SHALL be the eligible source with the highest pri; ties go to the lowest index.
REQ-021 The FSM SHALL have states IDLE, ARB and PRESENT.
REQ-022 IDLE SHALL go to ARB when any source is eligible.
REQ-023 ARB SHALL register the winner index, then go to PRESENT; this takes 1 cycle.
REQ-024 In PRESENT, cpu_irq SHALL be 1 and cpu_irq_vector SHALL equal VEC_BASE+index, held stable.
REQ-025 From eligibility to cpu_irq=1, latency SHALL be 2 clk cycles.
REQ-026 On cpu_irq_ack in PRESENT, the block SHALL clear the presented flag, drop cpu_irq the next cycle and return to IDLE.
REQ-027 If the presented source becomes ineligible in PRESENT before ack, the block SHALL withdraw cpu_irq the next cycle and return to IDLE. Causes: flag cleared, enable cleared, pri lowered, or cpu_ilevel raised.
REQ-028 A higher-priority source arriving during PRESENT SHALL NOT preempt; it wins the next arbitration.
REQ-029 cpu_irq_ack outside PRESENT SHALL be ignored.
REQ-030 In IDLE and ARB, cpu_irq SHALL be 0 and cpu_irq_vector SHALL be 8'h00.

Reset
REQ-031 While reset=0, all of the following SHALL be forced: pri, enable and flags to 0; FSM to IDLE; cpu_irq=0; cpu_irq_vector=0; the irq_in edge register to 0.
REQ-032 Reset asserted mid-PRESENT SHALL drop cpu_irq asynchronously, and the pending flag SHALL be lost.

Structure
REQ-033 A shared package irq_pkg SHALL hold the FSM state enum, the register address constants and VEC_BASE's default.
REQ-034 Arbitration SHALL be one combinational sub-module, irq_priority_encoder: inputs are the eligible mask and pri; outputs are valid and index.

Verification
REQ-035 The bench SHALL cover:
  1. pri0=3, en=01, ilevel=0, pulse irq_in[0]: cpu_irq=1 two cycles later, vector=8'h03; ack clears flag 0 and cpu_irq=0 the next cycle.
  2. Simultaneous irq_in[2] and irq_in[5], both pri=2, enabled: vector=8'h05 first; after ack, vector=8'h08.
  3. pri1=1, ilevel=1, flag set: cpu_irq stays 0; drop ilevel to 0: cpu_irq=1 two cycles later.
  4. In PRESENT for source 3, write 0x2027=8'h08: cpu_irq=0 the next cycle, FSM in IDLE.
  5. Edge on irq_in[4] in the same cycle as a write 0x2027=8'h10: flag 4 reads 1.
  6. Reset=0 asserted during PRESENT: cpu_irq=0 immediately; all registers read 8'h00.
